// File: rtl/seq_pkg.sv
// Shared definitions for the serializer and the downstream Mealy sequence detector.
//   ser_state_t      : serializer FSM encoding
//   det_state_t      : detector state codes, kept here so both stages share one definition
//   IDLE_BIT_DEFAULT : idle line level that keeps the detector parked in S0
package seq_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } ser_state_t;

    typedef enum logic [1:0] {
        DET_S0 = 2'd0,
        DET_S1 = 2'd1,
        DET_S2 = 2'd2,
        DET_S3 = 2'd3
    } det_state_t;

    localparam logic IDLE_BIT_DEFAULT = 1'b1;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous word FIFO, no fall-through; head is read combinationally from memory.
// Ports:
//   i_Clk, Reset      clock, async active-high reset (pointers/level cleared)
//   i_Push, i_Data    write request and word (ignored when full)
//   i_Pop             read request (ignored when empty)
//   o_Head            word at the read pointer
//   o_Full, o_Empty   decoded from the registered level
//   o_Level           words currently held
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       i_Clk,
    input  logic                       Reset,
    input  logic                       i_Push,
    input  logic [WIDTH-1:0]           i_Data,
    input  logic                       i_Pop,
    output logic [WIDTH-1:0]           o_Head,
    output logic                       o_Full,
    output logic                       o_Empty,
    output logic [$clog2(DEPTH):0]     o_Level
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    logic [WIDTH-1:0] r_Mem [DEPTH];
    logic [AW-1:0]    r_Wr_Ptr;
    logic [AW-1:0]    r_Rd_Ptr;
    logic [LW-1:0]    r_Level;
    logic             w_Do_Push;
    logic             w_Do_Pop;

    assign o_Full    = (r_Level == LW'(DEPTH));
    assign o_Empty   = (r_Level == '0);
    assign o_Level   = r_Level;
    assign o_Head    = r_Mem[r_Rd_Ptr];
    assign w_Do_Push = i_Push && !o_Full;
    assign w_Do_Pop  = i_Pop && !o_Empty;

    // Storage carries no reset; validity is tracked by the pointers and level.
    always_ff @(posedge i_Clk) begin
        if (w_Do_Push) begin
            r_Mem[r_Wr_Ptr] <= i_Data;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge i_Clk or posedge Reset) begin
        if (Reset) begin
            r_Wr_Ptr <= '0;
            r_Rd_Ptr <= '0;
            r_Level  <= '0;
        end else begin
            if (w_Do_Push) begin
                r_Wr_Ptr <= r_Wr_Ptr + 1'b1;
            end
            if (w_Do_Pop) begin
                r_Rd_Ptr <= r_Rd_Ptr + 1'b1;
            end
            case ({w_Do_Push, w_Do_Pop})
                2'b10:   r_Level <= r_Level + LW'(1);
                2'b01:   r_Level <= r_Level - LW'(1);
                default: r_Level <= r_Level;
            endcase
        end
    end

endmodule

// File: rtl/sequence_serializer.sv
// Parallel-to-serial feeder for the Mealy sequence detector.
// Words arrive over valid/ready into a small FIFO and are shifted out one bit per
// clock on o_Sequence; back-to-back words are gapless, idle fill is IDLE_BIT.
// Ports:
//   i_Clk, Reset     clock, async active-high reset
//   i_Data, i_Valid  input word and its valid
//   o_Ready          FIFO not full (combinational from registered level)
//   o_Sequence       serial bit stream
//   o_Bit_Valid      o_Sequence carries a data bit
//   o_Busy           shifting or FIFO non-empty
//   o_Level          words held in the FIFO
module sequence_serializer
    import seq_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned DEPTH     = 4,
    parameter logic        IDLE_BIT  = IDLE_BIT_DEFAULT,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic                       i_Clk,
    input  logic                       Reset,
    input  logic [WIDTH-1:0]           i_Data,
    input  logic                       i_Valid,
    output logic                       o_Ready,
    output logic                       o_Sequence,
    output logic                       o_Bit_Valid,
    output logic                       o_Busy,
    output logic [$clog2(DEPTH):0]     o_Level
);

    localparam int unsigned LW = $clog2(DEPTH) + 1;
    localparam int unsigned CW = $clog2(WIDTH);

    ser_state_t       r_State;
    logic [WIDTH-1:0] r_Shift;
    logic [CW-1:0]    r_Bit_Cnt;

    logic             w_Full;
    logic             w_Empty;
    logic [WIDTH-1:0] w_Head;
    logic [LW-1:0]    w_Level;
    logic             w_Push;
    logic             w_Pop;
    logic             w_Last;
    logic             w_Shift_Next;
    logic [LW-1:0]    w_Level_Next;

    // Bit that leaves the word first, and the word with that bit consumed.
    function automatic logic first_bit(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? w[WIDTH-1] : w[0];
    endfunction

    function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? (w << 1) : (w >> 1);
    endfunction

    sync_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_Clk   (i_Clk),
        .Reset   (Reset),
        .i_Push  (w_Push),
        .i_Data  (i_Data),
        .i_Pop   (w_Pop),
        .o_Head  (w_Head),
        .o_Full  (w_Full),
        .o_Empty (w_Empty),
        .o_Level (w_Level)
    );

    assign o_Ready = !w_Full;
    assign o_Level = w_Level;
    assign w_Push  = i_Valid && !w_Full;
    assign w_Last  = (r_Bit_Cnt == '0);

    // Pop from idle, or on the last bit of a word so the next one follows gaplessly.
    assign w_Pop        = !w_Empty && ((r_State == ST_IDLE) || w_Last);
    assign w_Shift_Next = ((r_State == ST_SHIFT) && !w_Last) || !w_Empty;
    assign w_Level_Next = w_Level + LW'(w_Push) - LW'(w_Pop);

    // FSM, shifter, bit counter and registered outputs.
    always_ff @(posedge i_Clk or posedge Reset) begin
        if (Reset) begin
            r_State     <= ST_IDLE;
            r_Shift     <= '0;
            r_Bit_Cnt   <= '0;
            o_Sequence  <= IDLE_BIT;
            o_Bit_Valid <= 1'b0;
            o_Busy      <= 1'b0;
        end else begin
            // Reflects the state and level that take effect on this edge.
            o_Busy <= w_Shift_Next || (w_Level_Next != '0);
            case (r_State)
                ST_SHIFT: begin
                    if (!w_Last) begin
                        r_Shift    <= advance(r_Shift);
                        r_Bit_Cnt  <= r_Bit_Cnt - 1'b1;
                        o_Sequence <= first_bit(r_Shift);
                    end else if (w_Pop) begin
                        r_Shift    <= advance(w_Head);
                        r_Bit_Cnt  <= CW'(WIDTH - 1);
                        o_Sequence <= first_bit(w_Head);
                    end else begin
                        r_State     <= ST_IDLE;
                        o_Sequence  <= IDLE_BIT;
                        o_Bit_Valid <= 1'b0;
                    end
                end
                default: begin
                    if (w_Pop) begin
                        r_State     <= ST_SHIFT;
                        r_Shift     <= advance(w_Head);
                        r_Bit_Cnt   <= CW'(WIDTH - 1);
                        o_Sequence  <= first_bit(w_Head);
                        o_Bit_Valid <= 1'b1;
                    end else begin
                        r_State     <= ST_IDLE;
                        o_Sequence  <= IDLE_BIT;
                        o_Bit_Valid <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sequence_serializer.sv
// Self-checking bench for sequence_serializer: scoreboard of (edge, bit) expectations
// built from accepted words, checked every cycle by an independent monitor.
module tb_sequence_serializer;

    localparam int W = 8;
    localparam int D = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] din;
    logic         vld;
    logic         rdy, seq, bv, busy;
    logic [2:0]   lvl;

    logic [W-1:0] din2;
    logic         vld2;
    logic         rdy2, seq2, bv2, busy2;
    logic [2:0]   lvl2;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    sequence_serializer #(.WIDTH(W), .DEPTH(D), .IDLE_BIT(1'b1), .MSB_FIRST(1'b1)) dut (
        .i_Clk(clk), .Reset(rst), .i_Data(din), .i_Valid(vld), .o_Ready(rdy),
        .o_Sequence(seq), .o_Bit_Valid(bv), .o_Busy(busy), .o_Level(lvl)
    );

    sequence_serializer #(.WIDTH(W), .DEPTH(D), .IDLE_BIT(1'b1), .MSB_FIRST(1'b0)) dut_lsb (
        .i_Clk(clk), .Reset(rst), .i_Data(din2), .i_Valid(vld2), .o_Ready(rdy2),
        .o_Sequence(seq2), .o_Bit_Valid(bv2), .o_Busy(busy2), .o_Level(lvl2)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s at t=%0t: got %0h, expected %0h", nm, $time, act, req);
        end
    endtask

    // Reference model: a word accepted at edge k starts at max(k+1, end of previous word)
    // and occupies W consecutive edges; it sits in the FIFO until its start edge.
    typedef struct {
        int   edge_n;
        logic b;
    } exp_bit_t;

    exp_bit_t exp_q[$];
    int       starts_q[$];
    int       cyc       = 0;
    int       next_free = 0;
    bit       acc_flag  = 1'b0;

    always @(posedge clk) begin : model_blk
        int s;
        cyc++;
        acc_flag = 1'b0;
        if (rst) begin
            exp_q.delete();
            starts_q.delete();
            next_free = 0;
        end else begin
            if (vld && (starts_q.size() < D)) begin
                s = (cyc + 1 > next_free) ? cyc + 1 : next_free;
                for (int i = 0; i < W; i++) begin
                    exp_bit_t e;
                    e.edge_n = s + i;
                    e.b      = din[W-1-i];
                    exp_q.push_back(e);
                end
                starts_q.push_back(s);
                next_free = s + W;
                acc_flag  = 1'b1;
            end
            while (starts_q.size() > 0 && starts_q[0] <= cyc) begin
                void'(starts_q.pop_front());
            end
        end
    end

    // Monitor: sample every output half a cycle after the edge.
    always @(negedge clk) begin : mon_blk
        logic ev, eb;
        if (!rst) begin
            if (exp_q.size() > 0 && exp_q[0].edge_n == cyc) begin
                ev = 1'b1;
                eb = exp_q[0].b;
                void'(exp_q.pop_front());
            end else begin
                ev = 1'b0;
                eb = 1'b1;
            end
            chk("bit_valid", 32'(bv), 32'(ev));
            chk("sequence", 32'(seq), 32'(eb));
            chk("level", 32'(lvl), 32'(starts_q.size()));
            chk("ready", 32'(rdy), 32'(starts_q.size() < D));
            chk("busy", 32'(busy), 32'(ev || (starts_q.size() != 0)));
        end
    end

    // Hold a word on i_Data with i_Valid until the model records acceptance.
    task automatic push_word(input logic [W-1:0] w);
        int t;
        din = w;
        vld = 1'b1;
        t   = 0;
        do begin
            @(posedge clk);
            #1;
            t++;
        end while (!acc_flag && t < 200);
        chk("push_accept", 32'(acc_flag), 32'd1);
        vld = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((exp_q.size() > 0 || starts_q.size() > 0) && t < 500) begin
            @(posedge clk);
            t++;
        end
        chk("drain", 32'(exp_q.size()), 32'd0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic [W-1:0] w2;
        rst  = 1'b1;
        din  = '0;
        vld  = 1'b0;
        din2 = '0;
        vld2 = 1'b0;
        #1;
        chk("rst_seq", 32'(seq), 32'd1);
        chk("rst_bv", 32'(bv), 32'd0);
        chk("rst_ready", 32'(rdy), 32'd1);
        chk("rst_level", 32'(lvl), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        repeat (3) @(posedge clk);
        #3 rst = 1'b0;

        // Idle after reset
        repeat (20) @(posedge clk);
        #1;
        chk("idle_seq", 32'(seq), 32'd1);
        chk("idle_level", 32'(lvl), 32'd0);

        // Single word
        push_word(8'h77);
        drain();

        // Two words back to back
        push_word(8'hA5);
        push_word(8'h3C);
        drain();

        // Six words with i_Valid held: backpressure and full FIFO
        push_word(8'h11);
        push_word(8'h22);
        push_word(8'h33);
        push_word(8'h44);
        push_word(8'h55);
        chk("full_level", 32'(lvl), 32'd4);
        chk("full_ready", 32'(rdy), 32'd0);
        push_word(8'h66);
        drain();

        // Reset in the middle of a word with two words queued
        push_word(8'h0F);
        push_word(8'hC3);
        push_word(8'h81);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midrst_seq", 32'(seq), 32'd1);
        chk("midrst_bv", 32'(bv), 32'd0);
        chk("midrst_level", 32'(lvl), 32'd0);
        chk("midrst_ready", 32'(rdy), 32'd1);
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        push_word(8'hF0);
        drain();

        // LSB-first instance
        w2 = 8'h01;
        @(negedge clk);
        chk("lsb_ready", 32'(rdy2), 32'd1);
        din2 = w2;
        vld2 = 1'b1;
        @(posedge clk);
        #1 vld2 = 1'b0;
        for (int i = 0; i < W; i++) begin
            @(posedge clk);
            #1;
            chk("lsb_bv", 32'(bv2), 32'd1);
            chk("lsb_bit", 32'(seq2), 32'((w2 >> i) & 8'h01));
        end
        @(posedge clk);
        #1;
        chk("lsb_idle_bv", 32'(bv2), 32'd0);
        chk("lsb_idle_seq", 32'(seq2), 32'd1);
        chk("lsb_idle_busy", 32'(busy2), 32'd0);
        chk("lsb_idle_level", 32'(lvl2), 32'd0);

        // Random traffic with random gaps
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 12)) @(posedge clk);
                #1;
            end
            push_word(W'($urandom));
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
